seven_seg_scan_ctrl: RTL and testbench

//  Parametrised multiplexed 7-segment display driver for StarterKit-class boards (generalises the 4-digit KW4-56 pin drive).

---
 rtl/seven_seg_pkg.sv | 37 +++
 rtl/seven_seg_hex_decoder.sv | 21 ++
 rtl/seven_seg_scan_ctrl.sv | 159 +++++++++++++++
 tb/tb_seven_seg_scan_ctrl.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/seven_seg_pkg.sv
// rtl/seven_seg_pkg.sv - shared constants and hex-to-segment table for the scan controller
package seven_seg_pkg;

  // Scan FSM states
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_BLANK = 2'd1;
  localparam logic [1:0] ST_ON    = 2'd2;

  // SEG bit positions, pattern is {dp,g,f,e,d,c,b,a}
  localparam int SEG_A  = 0;
  localparam int SEG_DP = 7;

  // Active-high segment pattern for a hex nibble, dp bit left clear
  function automatic logic [7:0] hex_to_seg(input logic [3:0] i_nibble);
    logic [7:0] w_seg;
    case (i_nibble)
      4'h0: w_seg = 8'h3F;
      4'h1: w_seg = 8'h06;
      4'h2: w_seg = 8'h5B;
      4'h3: w_seg = 8'h4F;
      4'h4: w_seg = 8'h66;
      4'h5: w_seg = 8'h6D;
      4'h6: w_seg = 8'h7D;
      4'h7: w_seg = 8'h07;
      4'h8: w_seg = 8'h7F;
      4'h9: w_seg = 8'h6F;
      4'hA: w_seg = 8'h77;
      4'hB: w_seg = 8'h7C;
      4'hC: w_seg = 8'h39;
      4'hD: w_seg = 8'h5E;
      4'hE: w_seg = 8'h79;
      default: w_seg = 8'h71;
    endcase
    return w_seg;
  endfunction

endpackage

// File: rtl/seven_seg_hex_decoder.sv
// rtl/seven_seg_hex_decoder.sv - nibble/dp/blank to active-high segment pattern
module seven_seg_hex_decoder
  import seven_seg_pkg::*;
(
  input  logic [3:0] i_nibble,
  input  logic       i_dp,
  input  logic       i_blank,
  output logic [7:0] o_pattern
);

  // A blanked digit stays fully dark, decimal point included
  always_comb begin
    o_pattern = 8'h00;
    if (!i_blank) begin
      o_pattern         = hex_to_seg(i_nibble);
      o_pattern[SEG_DP] = i_dp;
      o_pattern[SEG_A]  = hex_to_seg(i_nibble) >> SEG_A;
    end
  end

endmodule

// File: rtl/seven_seg_scan_ctrl.sv
// rtl/seven_seg_scan_ctrl.sv - multiplexed 7-segment scan driver with blanking, PWM and double-buffered data
module seven_seg_scan_ctrl
  import seven_seg_pkg::*;
#(
  parameter int C_DIGITS       = 4,
  parameter int C_SCAN_DIV     = 2500,
  parameter int C_BLANK_CYCLES = 16,
  parameter int C_BRIGHT_BITS  = 4,
  parameter bit C_SEG_ACT_LOW  = 1'b0,
  parameter bit C_DIG_ACT_LOW  = 1'b1
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_en,
  input  logic                     i_update_valid,
  output logic                     o_update_ready,
  input  logic [4*C_DIGITS-1:0]    i_update_data,
  input  logic [C_DIGITS-1:0]      i_update_dp,
  input  logic [C_DIGITS-1:0]      i_update_blank,
  input  logic [C_BRIGHT_BITS-1:0] i_brightness,
  output logic [7:0]               o_seg,
  output logic [C_DIGITS-1:0]      o_dig,
  output logic                     o_frame_done
);

  localparam int CW = (C_SCAN_DIV > 2) ? $clog2(C_SCAN_DIV) : 1;
  localparam int DW = (C_DIGITS > 1) ? $clog2(C_DIGITS) : 1;
  localparam logic [CW-1:0] BLANK_LAST = CW'(C_BLANK_CYCLES - 1);
  localparam logic [CW-1:0] ON_LAST    = CW'(C_SCAN_DIV - C_BLANK_CYCLES - 1);
  localparam logic [DW-1:0] DIG_LAST   = DW'(C_DIGITS - 1);
  localparam logic [7:0]          SEG_OFF = {8{C_SEG_ACT_LOW}};
  localparam logic [C_DIGITS-1:0] DIG_OFF = {C_DIGITS{C_DIG_ACT_LOW}};

  if ((C_SCAN_DIV <= C_BLANK_CYCLES) || (C_BLANK_CYCLES < 1) || (C_DIGITS < 1) || (C_DIGITS > 16)) begin : g_bad_params
    $error("seven_seg_scan_ctrl: C_SCAN_DIV must exceed C_BLANK_CYCLES (>=1), C_DIGITS in 1..16");
  end

  logic [1:0]               r_state;
  logic [CW-1:0]            r_cnt;
  logic [DW-1:0]            r_digit;
  logic [C_BRIGHT_BITS-1:0] r_pwm;
  logic [C_BRIGHT_BITS-1:0] r_bright;
  logic                     r_frame_done;
  logic [7:0]               r_seg;
  logic [C_DIGITS-1:0]      r_dig;
  logic [4*C_DIGITS-1:0]    r_act_data, r_pnd_data;
  logic [C_DIGITS-1:0]      r_act_dp, r_pnd_dp;
  logic [C_DIGITS-1:0]      r_act_blank, r_pnd_blank;
  logic                     r_pnd_full;

  logic                w_boundary, w_capture, w_transfer, w_on, w_dig_on;
  logic [3:0]          w_nibble;
  logic [7:0]          w_pattern;
  logic [C_DIGITS-1:0] w_dig_onehot;

  assign w_boundary     = (r_state == ST_ON) && (r_cnt == ON_LAST) && (r_digit == DIG_LAST);
  assign o_update_ready = !r_pnd_full && !i_rst;
  assign w_capture      = i_update_valid && o_update_ready;
  // r_frame_done marks the first cycle of a new frame, so a capture made on
  // that same cycle waits for the next boundary
  assign w_transfer     = r_pnd_full && (r_frame_done || (r_state == ST_IDLE));
  // EN gates the pins directly so they go dark on the cycle after EN drops
  assign w_on           = i_en && (r_state == ST_ON);
  assign w_dig_on       = w_on && (r_pwm < r_bright);
  assign w_nibble       = r_act_data[{r_digit, 2'b00} +: 4];
  assign w_dig_onehot   = C_DIGITS'(1) << r_digit;

  seven_seg_hex_decoder u_decoder (
    .i_nibble  (w_nibble),
    .i_dp      (r_act_dp[r_digit]),
    .i_blank   (r_act_blank[r_digit]),
    .o_pattern (w_pattern)
  );

  // Slot sequencer: BLANK then ON per digit, PWM counter restarted and brightness latched on ON entry
  always_ff @(posedge i_clk) begin
    if (i_rst || !i_en) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_digit <= '0;
      if (i_rst) begin
        r_pwm    <= '0;
        r_bright <= '0;
      end
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_state <= ST_BLANK;
          r_cnt   <= '0;
        end
        ST_BLANK: begin
          if (r_cnt == BLANK_LAST) begin
            r_state  <= ST_ON;
            r_cnt    <= '0;
            r_pwm    <= '0;
            r_bright <= i_brightness;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_ON: begin
          r_pwm <= r_pwm + 1'b1;
          if (r_cnt == ON_LAST) begin
            r_state <= ST_BLANK;
            r_cnt   <= '0;
            r_digit <= (r_digit == DIG_LAST) ? '0 : r_digit + 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Active buffer and pending-full flag; reset leaves the display dark and drops pending data
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_act_data  <= '0;
      r_act_dp    <= '0;
      r_act_blank <= '1;
      r_pnd_full  <= 1'b0;
    end else if (w_capture) begin
      r_pnd_full <= 1'b1;
    end else if (w_transfer) begin
      r_act_data  <= r_pnd_data;
      r_act_dp    <= r_pnd_dp;
      r_act_blank <= r_pnd_blank;
      r_pnd_full  <= 1'b0;
    end
  end

  // Pending buffer payload, only meaningful while r_pnd_full is set
  always_ff @(posedge i_clk) begin
    if (w_capture) begin
      r_pnd_data  <= i_update_data;
      r_pnd_dp    <= i_update_dp;
      r_pnd_blank <= i_update_blank;
    end
  end

  // Registered pins; polarity is applied only here
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_seg        <= SEG_OFF;
      r_dig        <= DIG_OFF;
      r_frame_done <= 1'b0;
    end else begin
      r_seg        <= w_on ? (w_pattern ^ SEG_OFF) : SEG_OFF;
      r_dig        <= w_dig_on ? (w_dig_onehot ^ DIG_OFF) : DIG_OFF;
      r_frame_done <= i_en && w_boundary;
    end
  end

  assign o_seg        = r_seg;
  assign o_dig        = r_dig;
  assign o_frame_done = r_frame_done;

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// tb/tb_seven_seg_scan_ctrl.sv - directed self-checking bench for seven_seg_scan_ctrl
module tb_seven_seg_scan_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst4, en4, valid4, ready4, fd4;
  logic [15:0] data4;
  logic [3:0]  dp4, blank4, bright4, dig4;
  logic [7:0]  seg4;

  logic        rst8, en8, valid8, ready8, fd8;
  logic [31:0] data8;
  logic [7:0]  dp8, blank8, dig8, seg8;
  logic [3:0]  bright8;

  int n_asserts = 0;
  int n_fail    = 0;
  int kpos      = 0;
  int at, n_act, n_bad, n_first;

  seven_seg_scan_ctrl #(
    .C_DIGITS(4), .C_SCAN_DIV(32), .C_BLANK_CYCLES(4), .C_BRIGHT_BITS(4),
    .C_SEG_ACT_LOW(1'b0), .C_DIG_ACT_LOW(1'b1)
  ) u_dut4 (
    .i_clk(clk), .i_rst(rst4), .i_en(en4), .i_update_valid(valid4), .o_update_ready(ready4),
    .i_update_data(data4), .i_update_dp(dp4), .i_update_blank(blank4), .i_brightness(bright4),
    .o_seg(seg4), .o_dig(dig4), .o_frame_done(fd4)
  );

  seven_seg_scan_ctrl #(
    .C_DIGITS(8), .C_SCAN_DIV(32), .C_BLANK_CYCLES(4), .C_BRIGHT_BITS(4),
    .C_SEG_ACT_LOW(1'b0), .C_DIG_ACT_LOW(1'b1)
  ) u_dut8 (
    .i_clk(clk), .i_rst(rst8), .i_en(en8), .i_update_valid(valid8), .o_update_ready(ready8),
    .i_update_data(data8), .i_update_dp(dp8), .i_update_blank(blank8), .i_brightness(bright8),
    .o_seg(seg8), .o_dig(dig8), .o_frame_done(fd8)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_asserts++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (k=%0d)", tag, got, exp, kpos);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
    kpos += n;
  endtask

  task automatic goto(input int target);
    if (target > kpos) step(target - kpos);
  endtask

  task automatic wait_frame(input bit big, output int cycles);
    bit found = 1'b0;
    int n = 0;
    while (!found && n < 2000) begin
      step(1);
      n++;
      if ((big ? fd8 : fd4) === 1'b1) found = 1'b1;
    end
    check_val("frame_done_seen", 32'(found), 32'd1);
    cycles = kpos;
    kpos = 0;
  endtask

  task automatic check_frame4(input logic [7:0] e0, input logic [7:0] e1,
                              input logic [7:0] e2, input logic [7:0] e3);
    logic [7:0] e [4];
    logic [3:0] ed;
    e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
    for (int d = 0; d < 4; d++) begin
      goto(32 * d + 5);
      ed = ~(4'(1) << d);
      check_val($sformatf("seg_digit%0d", d), 32'(seg4), 32'(e[d]));
      check_val($sformatf("dig_digit%0d", d), 32'(dig4), 32'(ed));
    end
  endtask

  initial begin
    rst4 = 1'b1; en4 = 1'b0; valid4 = 1'b0; data4 = '0; dp4 = '0; blank4 = '0; bright4 = 4'd15;
    rst8 = 1'b1; en8 = 1'b0; valid8 = 1'b0; data8 = '0; dp8 = '0; blank8 = '0; bright8 = 4'd15;

    // reset state
    step(2);
    check_val("rst_ready", 32'(ready4), 32'd0);
    check_val("rst_dig", 32'(dig4), 32'hF);
    check_val("rst_seg", 32'(seg4), 32'h0);
    check_val("rst_fd", 32'(fd4), 32'd0);
    rst4 = 1'b0;
    step(1);
    check_val("ready_after_rst", 32'(ready4), 32'd1);

    // write 1234 in IDLE, then scan
    data4 = 16'h1234; valid4 = 1'b1;
    step(1);
    check_val("ready_drop", 32'(ready4), 32'd0);
    valid4 = 1'b0;
    step(1);
    check_val("ready_idle_xfer", 32'(ready4), 32'd1);
    en4 = 1'b1; kpos = -1;
    goto(1);
    check_val("blank_k1_dig", 32'(dig4), 32'hF);
    check_val("blank_k1_seg", 32'(seg4), 32'h0);
    goto(4);
    check_val("blank_k4_dig", 32'(dig4), 32'hF);
    goto(5);
    check_val("slot0_seg", 32'(seg4), 32'h66);
    check_val("slot0_dig", 32'(dig4), 32'hE);
    goto(101);
    check_val("slot3_seg", 32'(seg4), 32'h06);
    check_val("slot3_dig", 32'(dig4), 32'h7);
    wait_frame(1'b0, at);
    check_val("frame_period_1", 32'(at), 32'd128);

    // back-to-back writes, the first one on the boundary cycle itself
    data4 = 16'h1111; valid4 = 1'b1;
    step(1);
    check_val("fd_pulse_width", 32'(fd4), 32'd0);
    check_val("ready_after_1111", 32'(ready4), 32'd0);
    data4 = 16'h2222;
    goto(5);
    check_val("boundary_capture_deferred", 32'(seg4), 32'h66);
    wait_frame(1'b0, at);
    check_val("stall_at_fd", 32'(ready4), 32'd0);
    step(1);
    check_val("ready_after_fd", 32'(ready4), 32'd1);
    step(1);
    check_val("ready_after_2222", 32'(ready4), 32'd0);
    valid4 = 1'b0;
    check_frame4(8'h06, 8'h06, 8'h06, 8'h06);
    wait_frame(1'b0, at);
    check_val("stall2_at_fd", 32'(ready4), 32'd0);
    step(1);
    check_val("ready2_after_fd", 32'(ready4), 32'd1);
    check_frame4(8'h5B, 8'h5B, 8'h5B, 8'h5B);

    // brightness 0 then 8
    bright4 = 4'd0;
    wait_frame(1'b0, at);
    n_act = 0; n_bad = 0;
    for (int i = 0; i < 128; i++) begin
      step(1);
      if (dig4 !== 4'hF) n_act++;
      if ((kpos % 32) >= 1 && (kpos % 32) <= 4 && (dig4 !== 4'hF || seg4 !== 8'h00)) n_bad++;
    end
    check_val("bright0_active", 32'(n_act), 32'd0);
    check_val("bright0_blank_phase", 32'(n_bad), 32'd0);
    check_val("bright0_frame_end", 32'(fd4), 32'd1);
    bright4 = 4'd8; kpos = 0;
    n_act = 0; n_bad = 0; n_first = 0;
    for (int i = 0; i < 128; i++) begin
      step(1);
      if (dig4 !== 4'hF) n_act++;
      if (kpos >= 5 && kpos <= 20 && dig4 !== 4'hF) n_first++;
      if ((kpos % 32) >= 1 && (kpos % 32) <= 4 && (dig4 !== 4'hF || seg4 !== 8'h00)) n_bad++;
    end
    check_val("bright8_active", 32'(n_act), 32'd64);
    check_val("bright8_first16", 32'(n_first), 32'd8);
    check_val("bright8_blank_phase", 32'(n_bad), 32'd0);
    check_val("bright8_frame_end", 32'(fd4), 32'd1);
    kpos = 0;

    // EN=0 during slot 2, write in IDLE, restart
    goto(69);
    check_val("pre_en_off_dig", 32'(dig4), 32'hB);
    check_val("pre_en_off_seg", 32'(seg4), 32'h5B);
    en4 = 1'b0;
    step(1);
    check_val("en_off_dig", 32'(dig4), 32'hF);
    check_val("en_off_seg", 32'(seg4), 32'h0);
    data4 = 16'h5678; valid4 = 1'b1;
    step(1);
    check_val("idle_write_ready0", 32'(ready4), 32'd0);
    valid4 = 1'b0;
    step(1);
    check_val("idle_write_ready1", 32'(ready4), 32'd1);
    en4 = 1'b1; kpos = -1;
    goto(4);
    check_val("restart_blank", 32'(dig4), 32'hF);
    check_frame4(8'h7F, 8'h07, 8'h7D, 8'h6D);
    wait_frame(1'b0, at);
    check_val("frame_period_restart", 32'(at), 32'd128);

    // reset mid-frame with pending full
    goto(33);
    data4 = 16'h9999; valid4 = 1'b1;
    step(1);
    valid4 = 1'b0;
    check_val("pending_full", 32'(ready4), 32'd0);
    goto(38);
    check_val("pre_rst_dig", 32'(dig4), 32'hD);
    check_val("pre_rst_seg", 32'(seg4), 32'h07);
    rst4 = 1'b1;
    step(1);
    check_val("mid_rst_dig", 32'(dig4), 32'hF);
    check_val("mid_rst_seg", 32'(seg4), 32'h0);
    check_val("mid_rst_ready", 32'(ready4), 32'd0);
    rst4 = 1'b0;
    step(1);
    check_val("post_rst_ready", 32'(ready4), 32'd1);
    n_bad = 0;
    for (int i = 0; i < 120; i++) begin
      step(1);
      if (seg4 !== 8'h00) n_bad++;
    end
    check_val("dark_after_rst", 32'(n_bad), 32'd0);
    data4 = 16'hAAAA; valid4 = 1'b1;
    step(1);
    valid4 = 1'b0;
    wait_frame(1'b0, at);
    check_val("frame_after_rst", 32'(at), 32'd168);
    check_frame4(8'h77, 8'h77, 8'h77, 8'h77);

    // 8-digit instance: blanked upper digits, dp on digit 0
    rst8 = 1'b0;
    step(1);
    check_val("ready8_after_rst", 32'(ready8), 32'd1);
    data8 = 32'h0000_0008; dp8 = 8'h01; blank8 = 8'hF0; valid8 = 1'b1;
    step(1);
    check_val("ready8_drop", 32'(ready8), 32'd0);
    valid8 = 1'b0;
    step(1);
    en8 = 1'b1; kpos = -1;
    goto(5);
    check_val("d8_digit0_seg", 32'(seg8), 32'hFF);
    check_val("d8_digit0_dig", 32'(dig8), 32'hFE);
    goto(37);
    check_val("d8_digit1_seg", 32'(seg8), 32'h3F);
    check_val("d8_digit1_dig", 32'(dig8), 32'hFD);
    goto(133);
    check_val("d8_digit4_seg", 32'(seg8), 32'h00);
    check_val("d8_digit4_dig", 32'(dig8), 32'hEF);
    goto(229);
    check_val("d8_digit7_seg", 32'(seg8), 32'h00);
    check_val("d8_digit7_dig", 32'(dig8), 32'h7F);
    wait_frame(1'b1, at);
    check_val("d8_frame_first", 32'(at), 32'd256);
    wait_frame(1'b1, at);
    check_val("d8_frame_period", 32'(at), 32'd256);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
